sipo_rx_ctrl: RTL and testbench

SIPO_RX_CTRL -- requirements
Module: sipo_rx_ctrl

---
 rtl/sipo_ctrl_pkg.sv | 27 ++
 rtl/sipo_shifter.sv | 38 +++
 rtl/sipo_rx_ctrl.sv | 150 +++++++++++++++
 tb/tb_sipo_rx_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/sipo_ctrl_pkg.sv
// sipo_ctrl_pkg
// Shared definitions for the serial-in / parallel-out receive controller:
// FSM state encoding, default frame width and the bit-counter width helper.
// Optional feature macro: SIPO_PARITY_EN adds the PARITY state.
package sipo_ctrl_pkg;

  localparam int SIPO_WIDTH_DEFAULT = 4;

`ifdef SIPO_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } sipo_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1
  } sipo_state_e;
`endif

  // Counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_shifter.sv
// sipo_shifter
// Left-shifting data register plus accepted-bit counter.
// Ports:
//   clk, reset (sync, active-low)
//   clr   : clear word and count (takes priority over en)
//   en    : shift din into the LSB and increment count
//   din   : serial bit
//   word  : current shift register contents
//   count : number of bits accepted since the last clear
module sipo_shifter
  import sipo_ctrl_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH_DEFAULT,
  parameter int CW    = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] word,
  output logic [CW-1:0]    count
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      word  <= '0;
      count <= '0;
    end else if (clr) begin
      word  <= '0;
      count <= '0;
    end else if (en) begin
      word  <= {word[WIDTH-2:0], din};
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/sipo_rx_ctrl.sv
// sipo_rx_ctrl
// Receives WIDTH-bit frames MSB first on din/din_en after a start strobe and
// presents them on q with a valid/ready handshake. A completed word that
// finds q still occupied is dropped and sets the sticky overrun flag.
// Optional feature macro: SIPO_PARITY_EN -- a trailing even-parity bit is
// checked after the data; a mismatch pulses parity_err and drops the word.
// Ports:
//   clk, reset (sync, active-low)
//   start      : frame-start strobe, also aborts a frame in progress
//   din/din_en : serial bit and its qualifier
//   out_ready  : consumer accepts q
//   q/q_valid  : output word and its valid flag
//   busy       : frame in progress
//   overrun    : sticky word-dropped flag
//   parity_err : one-cycle parity mismatch pulse (0 without SIPO_PARITY_EN)
//
// state  | meaning
// IDLE   | waiting for start
// SHIFT  | accepting data bits
// PARITY | waiting for the parity bit (SIPO_PARITY_EN only)
module sipo_rx_ctrl
  import sipo_ctrl_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             din,
  input  logic             din_en,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);

  localparam int CW = cnt_width(WIDTH);

  sipo_state_e      state, state_nxt;
  logic             sh_clr, sh_en;
  logic [WIDTH-1:0] sh_word;
  logic [CW-1:0]    sh_count;
  logic             last_bit;
  logic             frame_done;
  logic [WIDTH-1:0] frame_word;
`ifdef SIPO_PARITY_EN
  logic             par_fail;
`else
  // Without parity the word is taken from the shift path before its MSB
  // is shifted out, so the register MSB itself is never needed here.
  logic             unused_word_msb;
  assign unused_word_msb = sh_word[WIDTH-1];
`endif

  sipo_shifter #(.WIDTH(WIDTH), .CW(CW)) u_shifter (
    .clk   (clk),
    .reset (reset),
    .clr   (sh_clr),
    .en    (sh_en),
    .din   (din),
    .word  (sh_word),
    .count (sh_count)
  );

  assign last_bit = (sh_count == CW'(WIDTH - 1));
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    sh_clr     = 1'b0;
    sh_en      = 1'b0;
    frame_done = 1'b0;
    // Completing word includes the bit being sampled this edge.
    frame_word = {sh_word[WIDTH-2:0], din};
`ifdef SIPO_PARITY_EN
    par_fail   = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        // din_en alongside start is ignored: start only.
        if (start) begin
          sh_clr    = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (start) begin
          sh_clr = 1'b1;
        end else if (din_en) begin
          sh_en = 1'b1;
          if (last_bit) begin
`ifdef SIPO_PARITY_EN
            state_nxt = ST_PARITY;
`else
            frame_done = 1'b1;
            state_nxt  = ST_IDLE;
`endif
          end
        end
      end
`ifdef SIPO_PARITY_EN
      ST_PARITY: begin
        frame_word = sh_word;
        if (start) begin
          sh_clr    = 1'b1;
          state_nxt = ST_SHIFT;
        end else if (din_en) begin
          state_nxt = ST_IDLE;
          if (din == ^sh_word) frame_done = 1'b1;
          else                 par_fail   = 1'b1;
        end
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      q       <= '0;
      q_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (frame_done && (!q_valid || out_ready)) begin
        q       <= frame_word;
        q_valid <= 1'b1;
      end else begin
        if (out_ready)  q_valid <= 1'b0;
        if (frame_done) overrun <= 1'b1;
      end
    end
  end

`ifdef SIPO_PARITY_EN
  always_ff @(posedge clk) begin
    if (!reset) parity_err <= 1'b0;
    else        parity_err <= par_fail;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// Directed bench for sipo_rx_ctrl (WIDTH=4). Build with SIPO_PARITY_EN
// defined to exercise the parity path as well.
module tb_sipo_rx_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, din, din_en, out_ready;
  logic [3:0] q;
  logic       q_valid, busy, overrun, parity_err;
  int         errors = 0;
  int         checks = 0;

  sipo_rx_ctrl #(.WIDTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .din        (din),
    .din_en     (din_en),
    .out_ready  (out_ready),
    .q          (q),
    .q_valid    (q_valid),
    .busy       (busy),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    din    = b;
    din_en = 1'b1;
    step();
    din_en = 1'b0;
    din    = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Sends the trailing parity bit when parity is built in; no-op otherwise.
  task automatic send_par(input logic [3:0] w);
`ifdef SIPO_PARITY_EN
    send_bit(^w);
`endif
  endtask

  task automatic send_frame(input logic [3:0] w);
    for (int i = 3; i >= 0; i--) send_bit(w[i]);
    send_par(w);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; din = 1'b0; din_en = 1'b0; out_ready = 1'b1;
    step(); step();
    chk("rst_q", 16'(q), 16'h0);
    chk("rst_q_valid", 16'(q_valid), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_overrun", 16'(overrun), 16'h0);
    chk("rst_parity_err", 16'(parity_err), 16'h0);
    reset = 1'b1;
    step();

    // Back-to-back bits with consumer ready.
    do_start();
    chk("t1_busy", 16'(busy), 16'h1);
    send_frame(4'b1011);
    chk("t1_q", 16'(q), 16'hB);
    chk("t1_q_valid", 16'(q_valid), 16'h1);
    chk("t1_busy_after", 16'(busy), 16'h0);
    step();
    chk("t1_q_valid_1cyc", 16'(q_valid), 16'h0);

    // Gaps of two idle cycles between bits.
    do_start();
    send_bit(1'b1); step(); step();
    chk("t2_count_hold", 16'(dut.u_shifter.count), 16'h1);
    chk("t2_busy_gap", 16'(busy), 16'h1);
    send_bit(1'b1); step(); step();
    chk("t2_count_hold2", 16'(dut.u_shifter.count), 16'h2);
    send_bit(1'b0); step(); step();
    chk("t2_no_early", 16'(q_valid), 16'h0);
    send_bit(1'b0);
    send_par(4'b1100);
    chk("t2_q", 16'(q), 16'hC);
    chk("t2_q_valid", 16'(q_valid), 16'h1);
    step();

    // Overrun: second word dropped while first not consumed.
    out_ready = 1'b0;
    do_start();
    send_frame(4'b1010);
    chk("t3_q_first", 16'(q), 16'hA);
    chk("t3_overrun_pre", 16'(overrun), 16'h0);
    do_start();
    send_frame(4'b0101);
    chk("t3_q_kept", 16'(q), 16'hA);
    chk("t3_q_valid_kept", 16'(q_valid), 16'h1);
    chk("t3_overrun", 16'(overrun), 16'h1);
    out_ready = 1'b1;
    step();
    chk("t3_q_valid_clr", 16'(q_valid), 16'h0);
    chk("t3_overrun_sticky", 16'(overrun), 16'h1);

    // Abort by restart mid-frame.
    do_start();
    send_bit(1'b1); send_bit(1'b1);
    do_start();
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    chk("t4_no_partial", 16'(q_valid), 16'h0);
    send_bit(1'b1);
    send_par(4'b0001);
    chk("t4_q", 16'(q), 16'h1);
    chk("t4_q_valid", 16'(q_valid), 16'h1);

    // Reset mid-frame overrides all inputs.
    do_start();
    send_bit(1'b0); send_bit(1'b1);
    reset = 1'b0; din = 1'b1; din_en = 1'b1; start = 1'b1;
    step();
    chk("t5_rst_q", 16'(q), 16'h0);
    chk("t5_rst_q_valid", 16'(q_valid), 16'h0);
    chk("t5_rst_busy", 16'(busy), 16'h0);
    chk("t5_rst_overrun", 16'(overrun), 16'h0);
    chk("t5_rst_count", 16'(dut.u_shifter.count), 16'h0);
    reset = 1'b1; din = 1'b0; din_en = 1'b0; start = 1'b0;
    step();
    send_frame(4'b1111);
    chk("t5_need_start", 16'(q_valid), 16'h0);
    chk("t5_idle_busy", 16'(busy), 16'h0);
    do_start();
    send_frame(4'b0110);
    chk("t5_q", 16'(q), 16'h6);
    chk("t5_q_valid", 16'(q_valid), 16'h1);
    step();

    // start with din_en in IDLE: that din is not sampled.
    start = 1'b1; din = 1'b1; din_en = 1'b1;
    step();
    start = 1'b0; din = 1'b0; din_en = 1'b0;
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    chk("t6_not_sampled", 16'(q_valid), 16'h0);
    send_bit(1'b1);
    send_par(4'b0011);
    chk("t6_q", 16'(q), 16'h3);
    step();

`ifdef SIPO_PARITY_EN
    do_start();
    for (int i = 3; i >= 0; i--) send_bit(4'hB >> i);
    send_bit(1'b1);
    chk("p_ok_q", 16'(q), 16'hB);
    chk("p_ok_err", 16'(parity_err), 16'h0);
    step();
    do_start();
    for (int i = 3; i >= 0; i--) send_bit(4'hB >> i);
    send_bit(1'b0);
    chk("p_bad_err", 16'(parity_err), 16'h1);
    chk("p_bad_q_valid", 16'(q_valid), 16'h0);
    step();
    chk("p_bad_pulse", 16'(parity_err), 16'h0);
    chk("p_bad_idle", 16'(busy), 16'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
